// File: rtl/exec_unit_pkg.sv
// ============================================================================
// Module   : exec_unit_pkg
// Purpose  : Shared op encodings, FSM states and width defaults.
// Revision : 1.0
// ============================================================================
`default_nettype none

package exec_unit_pkg;

  localparam int W_DEFAULT = 8;
  localparam int D_DEFAULT = 4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRL  = 4'h6,
    OP_MUL  = 4'h7,
    OP_MOV  = 4'h8,
    OP_HALT = 4'h9,
    OP_NOP  = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Single-cycle ops that produce a write-back; MUL and NOP/undefined excluded.
  function automatic logic writes_back(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_MOV, OP_HALT: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/exec_unit_mul_iter.sv
// ============================================================================
// Module   : mul_iter
// Purpose  : Iterative shift-add multiplier, one multiplier bit per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_iter
  import exec_unit_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         i_start,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_done,
  output logic [W-1:0] o_product
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_mcand;
  logic [W-1:0]  r_mplier;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_cnt    <= CW'(W);
    end else if (r_cnt != '0) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
    end
  end

  // The final partial product is folded in combinationally so the caller
  // can register the full product on the W-th cycle after start.
  assign o_done    = (r_cnt == CW'(1));
  assign o_product = w_acc_next;

endmodule

`default_nettype wire

// File: rtl/exec_unit.sv
// ============================================================================
// Module   : exec_unit
// Purpose  : Execute stage: single-cycle ALU ops plus iterative MUL, registered write-back.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int D = D_DEFAULT
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [3:0]   Op,
  input  logic [D-1:0] Dest,
  input  logic [W-1:0] OperandA,
  input  logic [W-1:0] OperandB,
  output logic         Busy,
  output logic         WriteEn,
  output logic [D-1:0] Waddr,
  output logic [W-1:0] Result,
  output logic         Zero,
  output logic         Done
);

  state_e       r_state;
  state_e       w_state_next;
  logic [D-1:0] r_dest;
  logic [W-1:0] w_alu;
  logic         w_mul_start;
  logic         w_mul_done;
  logic [W-1:0] w_mul_product;

  logic         w_busy_next;
  logic         w_we_next;
  logic [D-1:0] w_waddr_next;
  logic [W-1:0] w_result_next;
  logic         w_zero_next;
  logic         w_done_next;

  // Start is honoured in IDLE and WB alike, so issue can overlap a write-back.
  assign w_mul_start = Start && (r_state != ST_MULT) && (Op == OP_MUL);

  mul_iter #(.W(W)) u_mul (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_start   (w_mul_start),
    .i_a       (OperandA),
    .i_b       (OperandB),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  always_comb begin
    w_alu = '0;
    case (Op)
      OP_ADD:  w_alu = OperandA + OperandB;
      OP_SUB:  w_alu = OperandA - OperandB;
      OP_AND:  w_alu = OperandA & OperandB;
      OP_OR:   w_alu = OperandA | OperandB;
      OP_XOR:  w_alu = OperandA ^ OperandB;
      OP_SLL:  w_alu = OperandA << OperandB[2:0];
      OP_SRL:  w_alu = OperandA >> OperandB[2:0];
      OP_MOV:  w_alu = OperandB;
      OP_HALT: w_alu = OperandA;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_busy_next   = 1'b0;
    w_we_next     = 1'b0;
    w_waddr_next  = Waddr;
    w_result_next = Result;
    w_zero_next   = Zero;
    w_done_next   = Done;
    case (r_state)
      ST_MULT: begin
        w_busy_next = 1'b1;
        if (w_mul_done) begin
          w_state_next  = ST_WB;
          w_busy_next   = 1'b0;
          w_we_next     = 1'b1;
          w_waddr_next  = r_dest;
          w_result_next = w_mul_product;
          w_zero_next   = (w_mul_product == '0);
          w_done_next   = 1'b0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        if (Start) begin
          if (Op == OP_MUL) begin
            w_state_next = ST_MULT;
            w_busy_next  = 1'b1;
          end else if (writes_back(Op)) begin
            w_we_next     = 1'b1;
            w_waddr_next  = Dest;
            w_result_next = w_alu;
            w_zero_next   = (w_alu == '0);
            w_done_next   = (Op == OP_HALT);
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Busy    <= 1'b0;
      WriteEn <= 1'b0;
      Waddr   <= '0;
      Result  <= '0;
      Zero    <= 1'b0;
      Done    <= 1'b0;
      r_dest  <= '0;
    end else begin
      Busy    <= w_busy_next;
      WriteEn <= w_we_next;
      Waddr   <= w_waddr_next;
      Result  <= w_result_next;
      Zero    <= w_zero_next;
      Done    <= w_done_next;
      if (w_mul_start) r_dest <= Dest;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
// ============================================================================
// Module   : tb_exec_unit
// Purpose  : Self-checking bench for exec_unit against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_exec_unit;
  import exec_unit_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic [3:0]   Op = 4'h0;
  logic [D-1:0] Dest = '0;
  logic [W-1:0] OperandA = '0;
  logic [W-1:0] OperandB = '0;
  logic         Busy, WriteEn, Zero, Done;
  logic [D-1:0] Waddr;
  logic [W-1:0] Result;

  int n_cmp = 0;
  int n_err = 0;

  exec_unit #(.W(W), .D(D)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .Dest(Dest),
    .OperandA(OperandA), .OperandB(OperandB), .Busy(Busy), .WriteEn(WriteEn),
    .Waddr(Waddr), .Result(Result), .Zero(Zero), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Reference model: plain integer arithmetic truncated to W bits.
  function automatic logic [W-1:0] model_result(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned ai, bi, r;
    ai = a; bi = b; r = 0;
    case (op)
      OP_ADD:  r = ai + bi;
      OP_SUB:  r = ai - bi;
      OP_AND:  r = ai & bi;
      OP_OR:   r = ai | bi;
      OP_XOR:  r = ai ^ bi;
      OP_SLL:  r = ai * (2 ** (bi % 8));
      OP_SRL:  r = ai / (2 ** (bi % 8));
      OP_MUL:  r = ai * bi;
      OP_MOV:  r = bi;
      OP_HALT: r = ai;
      default: r = 0;
    endcase
    return r[W-1:0];
  endfunction

  function automatic bit model_writes(input logic [3:0] op);
    return (op <= 4'h9);
  endfunction

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [D-1:0] dst);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b; Dest = dst;
  endtask

  // Consumes the issue edge, then observes until the first WriteEn (lat=0 if none).
  task automatic watch(input int max_cyc, output int lat, output logic [W-1:0] res,
                       output logic [D-1:0] wa, output logic z, output logic dn);
    step();
    Start = 1'b0;
    lat = 0; res = '0; wa = '0; z = 1'b0; dn = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge Clk);
      if (WriteEn === 1'b1) begin
        lat = c; res = Result; wa = Waddr; z = Zero; dn = Done;
        step();
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    issue(OP_ADD, 8'h01, 8'h01, 4'h1);
    step(); step();
    @(negedge Clk);
    n_cmp++; if (WriteEn !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b expected 0", WriteEn); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    n_cmp++; if ({Zero, Done} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b expected 00", {Zero, Done}); end
    n_cmp++; if (Result !== '0) begin n_err++; $display("FAIL reset_result: got %h expected 00", Result); end
    n_cmp++; if (Waddr !== '0) begin n_err++; $display("FAIL reset_waddr: got %h expected 0", Waddr); end
    step();
    Reset = 1'b0; Start = 1'b0;
    step();
  endtask

  task automatic test_add();
    int lat; logic [W-1:0] res; logic [D-1:0] wa; logic z, dn;
    issue(OP_ADD, 8'hF0, 8'h10, 4'd3);
    watch(3, lat, res, wa, z, dn);
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL add_latency: got %0d expected 1", lat); end
    n_cmp++; if (wa !== 4'd3) begin n_err++; $display("FAIL add_waddr: got %h expected 3", wa); end
    n_cmp++; if (res !== 8'h00) begin n_err++; $display("FAIL add_result: got %h expected 00", res); end
    n_cmp++; if ({z, dn} !== 2'b10) begin n_err++; $display("FAIL add_flags: got %b expected 10", {z, dn}); end
  endtask

  task automatic test_mul();
    int nwr = 0, busy = 0, lat = 0;
    logic [W-1:0] res = '0; logic [D-1:0] wa = '0; logic z = 1'b1;
    issue(OP_MUL, 8'd13, 8'd11, 4'd6);
    step();
    Start = 1'b0;
    for (int c = 1; c <= W + 5; c++) begin
      @(negedge Clk);
      if (WriteEn === 1'b1) begin
        nwr++;
        if (nwr == 1) begin lat = c; res = Result; wa = Waddr; z = Zero; end
      end
      if (Busy === 1'b1) busy++;
      step();
      if (c == 3) issue(OP_ADD, 8'h01, 8'h02, 4'd7);
      if (c == 4) Start = 1'b0;
    end
    n_cmp++; if (busy != W) begin n_err++; $display("FAIL mul_busy_cycles: got %0d expected %0d", busy, W); end
    n_cmp++; if (lat != W + 1) begin n_err++; $display("FAIL mul_latency: got %0d expected %0d", lat, W + 1); end
    n_cmp++; if (nwr != 1) begin n_err++; $display("FAIL mul_write_count: got %0d expected 1", nwr); end
    n_cmp++; if (res !== 8'h8F) begin n_err++; $display("FAIL mul_result: got %h expected 8f", res); end
    n_cmp++; if (wa !== 4'd6) begin n_err++; $display("FAIL mul_waddr: got %h expected 6", wa); end
    n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL mul_zero: got %b expected 0", z); end
  endtask

  task automatic test_mul_zero();
    int lat; logic [W-1:0] res; logic [D-1:0] wa; logic z, dn;
    issue(OP_MUL, 8'h00, 8'h5A, 4'd2);
    watch(W + 3, lat, res, wa, z, dn);
    n_cmp++; if (lat != W + 1) begin n_err++; $display("FAIL mulzero_latency: got %0d expected %0d", lat, W + 1); end
    n_cmp++; if ({res, z} !== {8'h00, 1'b1}) begin n_err++; $display("FAIL mulzero_result: got %h/%b expected 00/1", res, z); end
  endtask

  task automatic test_back_to_back();
    issue(OP_SUB, 8'd5, 8'd7, 4'd1);
    step();
    issue(OP_SLL, 8'h81, 8'h09, 4'd2);
    @(negedge Clk);
    n_cmp++; if ({WriteEn, Result, Waddr} !== {1'b1, 8'hFE, 4'd1})
      begin n_err++; $display("FAIL b2b_first: got we=%b res=%h wa=%h expected we=1 res=fe wa=1", WriteEn, Result, Waddr); end
    step();
    Start = 1'b0;
    @(negedge Clk);
    n_cmp++; if ({WriteEn, Result, Waddr} !== {1'b1, 8'h02, 4'd2})
      begin n_err++; $display("FAIL b2b_second: got we=%b res=%h wa=%h expected we=1 res=02 wa=2", WriteEn, Result, Waddr); end
    step();
  endtask

  task automatic test_reset_mid_mul();
    int nwr = 0;
    issue(OP_MUL, 8'hFF, 8'hFF, 4'd9);
    step();
    Start = 1'b0;
    step(); step(); step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    @(negedge Clk);
    n_cmp++; if ({Busy, WriteEn, Zero, Done} !== 4'b0000)
      begin n_err++; $display("FAIL rstmul_ctrl: got %b expected 0000", {Busy, WriteEn, Zero, Done}); end
    n_cmp++; if ({Result, Waddr} !== '0)
      begin n_err++; $display("FAIL rstmul_data: got %h/%h expected 00/0", Result, Waddr); end
    for (int c = 0; c < W + 4; c++) begin
      step();
      @(negedge Clk);
      if (WriteEn === 1'b1) nwr++;
    end
    step();
    n_cmp++; if (nwr != 0) begin n_err++; $display("FAIL rstmul_no_write: got %0d writes expected 0", nwr); end
  endtask

  task automatic test_halt_nop();
    int lat; logic [W-1:0] res; logic [D-1:0] wa; logic z, dn;
    issue(OP_HALT, 8'h2A, 8'h33, 4'd5);
    watch(3, lat, res, wa, z, dn);
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL halt_latency: got %0d expected 1", lat); end
    n_cmp++; if ({wa, res, dn, z} !== {4'd5, 8'h2A, 1'b1, 1'b0})
      begin n_err++; $display("FAIL halt_out: got wa=%h res=%h done=%b zero=%b expected 5 2a 1 0", wa, res, dn, z); end
    issue(OP_NOP, 8'h11, 8'h22, 4'd4);
    watch(W + 3, lat, res, wa, z, dn);
    n_cmp++; if (lat != 0) begin n_err++; $display("FAIL nop_write: got write at %0d expected none", lat); end
    issue(4'hC, 8'h11, 8'h22, 4'd4);
    watch(W + 3, lat, res, wa, z, dn);
    n_cmp++; if (lat != 0) begin n_err++; $display("FAIL undef_write: got write at %0d expected none", lat); end
  endtask

  task automatic test_random();
    int lat, exp_lat; logic [W-1:0] res, exp_res; logic [D-1:0] wa; logic z, dn;
    logic [3:0] op; logic [W-1:0] a, b; logic [D-1:0] dst;
    for (int i = 0; i < 40; i++) begin
      op  = 4'($urandom_range(0, 15));
      a   = W'($urandom);
      b   = W'($urandom);
      dst = D'($urandom);
      exp_res = model_result(op, a, b);
      exp_lat = !model_writes(op) ? 0 : (op == OP_MUL) ? W + 1 : 1;
      issue(op, a, b, dst);
      watch(W + 3, lat, res, wa, z, dn);
      n_cmp++;
      if (lat != exp_lat) begin
        n_err++; $display("FAIL rand_latency[%0d] op=%h: got %0d expected %0d", i, op, lat, exp_lat);
      end else if (exp_lat != 0) begin
        n_cmp++;
        if ({res, wa, z, dn} !== {exp_res, dst, (exp_res == '0), (op == OP_HALT)}) begin
          n_err++;
          $display("FAIL rand_out[%0d] op=%h a=%h b=%h: got res=%h wa=%h z=%b d=%b expected res=%h wa=%h z=%b d=%b",
                   i, op, a, b, res, wa, z, dn, exp_res, dst, (exp_res == '0), (op == OP_HALT));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_mul_zero();
    test_back_to_back();
    test_reset_mid_mul();
    test_halt_nop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
